load_store_io: RTL and testbench
================================

Name: load_store_io

Overview:
- Parametrised I/O unit between the processor's load/store stage and the external pins; successor to the single-channel read_in/write_out path.
- Provides NUM_IN latched input channels, each with a sticky valid flag and an overrun flag.
- Provides an OUT_DEPTH-entry output FIFO with a valid/ready handshake, and a readable status word.
- The processor reaches it through a small address map, stalling on stores to a full FIFO.

Parameters:
- WIDTH, 16, data width of every channel, FIFO entry and bus word.
- NUM_IN, 2, number of input channels, 1..8.
- OUT_DEPTH, 4, output FIFO depth, power of two, >= 2.
- Constraint: WIDTH >= NUM_IN + 3 + CW, where CW = clog2(OUT_DEPTH) + 1.

Ports:
- clock  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- addr  in  4  load/store address.
- rd_en  in  1  load request.
- wr_en  in  1  store request.
- wdata  in  WIDTH  store data.
- rdata  out  WIDTH  load data, registered.
- stall  out  1  store not accepted this cycle.
- read_in  in  NUM_IN*WIDTH  external input data; channel i is slice [i*WIDTH +: WIDTH].
- in_strobe  in  NUM_IN  per-channel capture pulse.
- write_out  out  WIDTH  FIFO head data.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  external consumer accepts the head.

Behaviour:
- Reset (rst low, asynchronous):
  - rdata = 0, write_out = 0.
  - FIFO empty, out_valid = 0.
  - All hold registers, valid flags and overrun flags = 0.
  - stall follows its combinational equation; with FIFO empty it is 0.
- Address map:
  - 0..NUM_IN-1: input channel hold register (load only).
  - 8: output FIFO push (store only).
  - 9: status word (load only).
  - Any other address: loads return 0, stores are ignored.
- Status word:
  - [NUM_IN-1:0] valid flags.
  - [NUM_IN] sticky overrun (OR of all channels).
  - [NUM_IN+1] fifo_empty.
  - [NUM_IN+2] fifo_full.
  - [NUM_IN+3 +: CW] fifo_count.
  - Upper bits 0.
- Loads:
  - rdata is updated on the clock edge after rd_en (1-cycle latency) and holds its value otherwise.
  - A load of channel i returns the hold value before any same-cycle capture.
  - A load of channel i clears valid[i] and overrun[i], unless in_strobe[i] is high that cycle; in that case the new data is captured, valid[i] stays 1 and overrun[i] clears.
  - A status load is side-effect free.
- Input capture:
  - in_strobe[i] high at an edge: hold[i] <= read_in slice i, valid[i] <= 1.
  - If valid[i] was already 1 and no same-cycle load of i occurs, overrun[i] <= 1.
  - Each channel is independent; simultaneous strobes on all channels are legal.
- Stores:
  - stall = wr_en & (addr == 8) & fifo_full, combinational.
  - A store is accepted when wr_en & (addr == 8) & !fifo_full; wdata is written at the tail.
  - A stalled store is dropped by this block; the processor holds the request until stall falls.
  - rd_en and wr_en together: both are honoured; stores to read-only addresses are ignored.
- FIFO:
  - write_out = head entry, or 0 when empty.
  - out_valid = !fifo_empty.
  - Pop occurs on out_valid & out_ready.
  - Push into an empty FIFO: out_valid and write_out appear the cycle after the accepting edge (no bypass).
  - Push and pop in the same cycle (not full): count unchanged, order preserved.
  - When full, a same-cycle pop does not allow a push: stall stays 1 that cycle.
  - Pointers wrap modulo OUT_DEPTH; count ranges 0..OUT_DEPTH.
- Reset mid-operation: the FIFO, flags and rdata clear immediately; no partial transfer survives.

Test Plan:
- Reset release, then status load -> rdata = 16'h0008 (empty = 1 at bit 3), out_valid = 0, write_out = 0.
- in_strobe[0] with read_in[15:0] = 16'h13b0, then load addr 0 -> rdata = 16'h13b0 one cycle later; a following status load shows bit 0 clear.
- Two strobes on ch1 (16'h1234, then 16'h0003) with no load -> status bits 1 and 2 set; load addr 1 returns 16'h0003 and clears both bits.
- Four stores (16'h000b, 16'h0003, 16'h1234, 16'hffff) with out_ready = 0 -> full = 1 and count = 4; a fifth store asserts stall; raising out_ready drains the four values in order, and out_valid falls after the last.
- Steady push and pop at count 2 for 10 cycles -> count stays 2, output sequence equals input sequence, wrap-around verified.
- Drive rst low while the FIFO holds 3 entries and valid[0] = 1 -> outputs are 0 immediately and status after release reads 16'h0008.

Source files
------------

// File: rtl/load_store_io_if.sv
// Processor load/store bus plus the output-FIFO handshake for load_store_io.
interface load_store_io_if #(
  parameter int unsigned WIDTH = 16
);
  logic [3:0]       addr;
  logic             rd_en;
  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             stall;
  logic [WIDTH-1:0] write_out;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output addr, rd_en, wr_en, wdata, out_ready,
    input  rdata, stall, write_out, out_valid
  );

  modport slave (
    input  addr, rd_en, wr_en, wdata, out_ready,
    output rdata, stall, write_out, out_valid
  );
endinterface

// File: rtl/load_store_io.sv
// Memory-mapped I/O unit: NUM_IN latched input channels with valid/overrun
// flags, an OUT_DEPTH output FIFO with valid/ready handshake, and a status word.
module load_store_io #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned NUM_IN    = 2,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    rst,
  load_store_io_if.slave          bus,
  input  logic [NUM_IN*WIDTH-1:0] read_in,
  input  logic [NUM_IN-1:0]       in_strobe
);

  localparam int unsigned AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned CW = $clog2(OUT_DEPTH) + 1;
  localparam logic [3:0] ADDR_PUSH   = 4'd8;
  localparam logic [3:0] ADDR_STATUS = 4'd9;

  logic [WIDTH-1:0]  hold [NUM_IN];
  logic [NUM_IN-1:0] valid;
  logic [NUM_IN-1:0] overrun;
  logic [NUM_IN-1:0] load_hit;

  logic [WIDTH-1:0]  mem [OUT_DEPTH];
  logic [AW-1:0]     head;
  logic [AW-1:0]     tail;
  logic [CW-1:0]     count;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push_req;
  logic              push;
  logic              pop;

  logic [WIDTH-1:0]  status;
  logic [WIDTH-1:0]  load_data;
  logic [WIDTH-1:0]  rdata_q;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(OUT_DEPTH));
  assign push_req   = bus.wr_en & (bus.addr == ADDR_PUSH);
  assign push       = push_req & ~fifo_full;
  // Full blocks the push even when the head pops in the same cycle.
  assign pop        = ~fifo_empty & bus.out_ready;

  assign bus.stall     = push_req & fifo_full;
  assign bus.out_valid = ~fifo_empty;
  assign bus.write_out = fifo_empty ? '0 : mem[head];
  assign bus.rdata     = rdata_q;

  always_comb begin
    status                  = '0;
    status[NUM_IN-1:0]      = valid;
    status[NUM_IN]          = |overrun;
    status[NUM_IN+1]        = fifo_empty;
    status[NUM_IN+2]        = fifo_full;
    status[NUM_IN+3 +: CW]  = count;
  end

  always_comb begin
    load_data = '0;
    load_hit  = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (bus.addr == 4'(i)) begin
        load_data   = hold[i];
        load_hit[i] = bus.rd_en;
      end
    end
    if (bus.addr == ADDR_STATUS) load_data = status;
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (bus.rd_en) begin
      rdata_q <= load_data;
    end
  end

  // A load and a capture on the same channel: the load sees the old hold value,
  // the flag stays set and overrun clears because the old value was consumed.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_IN; i++) hold[i] <= '0;
      valid   <= '0;
      overrun <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        if (in_strobe[i]) begin
          hold[i]    <= read_in[i*WIDTH +: WIDTH];
          valid[i]   <= 1'b1;
          overrun[i] <= ~load_hit[i] & (overrun[i] | valid[i]);
        end else if (load_hit[i]) begin
          valid[i]   <= 1'b0;
          overrun[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[tail] <= bus.wdata;
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_load_store_io.sv
// Self-checking bench for load_store_io: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_load_store_io;
  localparam int WIDTH  = 16;
  localparam int NUM_IN = 2;
  localparam int DEPTH  = 4;

  logic clock = 1'b0;
  logic rst;
  logic [NUM_IN*WIDTH-1:0] read_in;
  logic [NUM_IN-1:0]       in_strobe;

  load_store_io_if #(.WIDTH(WIDTH)) bus ();

  load_store_io #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .OUT_DEPTH(DEPTH)) dut (
    .clock     (clock),
    .rst       (rst),
    .bus       (bus.slave),
    .read_in   (read_in),
    .in_strobe (in_strobe)
  );

  always #5 clock = ~clock;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model state
  logic [WIDTH-1:0] m_hold  [NUM_IN];
  bit               m_valid [NUM_IN];
  bit               m_ovr   [NUM_IN];
  logic [WIDTH-1:0] m_rdata;
  logic [WIDTH-1:0] m_q [$];

  task automatic reset_model();
    for (int i = 0; i < NUM_IN; i++) begin
      m_hold[i] = '0; m_valid[i] = 0; m_ovr[i] = 0;
    end
    m_rdata = '0;
    m_q.delete();
  endtask

  function automatic logic [WIDTH-1:0] m_status();
    int s = 0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (m_valid[i]) s += (1 << i);
      if (m_ovr[i])   s |= (1 << NUM_IN);
    end
    if (m_q.size() == 0)     s += (1 << (NUM_IN + 1));
    if (m_q.size() == DEPTH) s += (1 << (NUM_IN + 2));
    s += m_q.size() << (NUM_IN + 3);
    return WIDTH'(s);
  endfunction

  task automatic drive_idle();
    bus.addr = '0; bus.rd_en = 0; bus.wr_en = 0; bus.wdata = '0;
    bus.out_ready = 0; in_strobe = '0; read_in = '0;
  endtask

  // Advance the model by one edge using the currently driven inputs, then clock.
  task automatic step();
    bit full;
    bit ld;
    logic [WIDTH-1:0] r;
    full = (m_q.size() == DEPTH);
    r = m_rdata;
    if (bus.rd_en) begin
      if (int'(bus.addr) < NUM_IN) r = m_hold[int'(bus.addr)];
      else if (bus.addr == 4'd9)   r = m_status();
      else                         r = '0;
    end
    for (int i = 0; i < NUM_IN; i++) begin
      ld = bus.rd_en && (int'(bus.addr) == i);
      if (in_strobe[i]) begin
        m_ovr[i]   = !ld && (m_ovr[i] || m_valid[i]);
        m_valid[i] = 1;
        m_hold[i]  = read_in[i*WIDTH +: WIDTH];
      end else if (ld) begin
        m_valid[i] = 0;
        m_ovr[i]   = 0;
      end
    end
    if (m_q.size() != 0 && bus.out_ready) void'(m_q.pop_front());
    if (bus.wr_en && bus.addr == 4'd8 && !full) m_q.push_back(bus.wdata);
    m_rdata = r;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    #2 rst = 1'b0;
    reset_model();
    bus.wr_en = 1; bus.addr = 4'd8;
    repeat (2) @(posedge clock);
    #1;
    total_cnt++; if (bus.rdata !== 16'h0) $display("FAIL reset_rdata got %h want %h", bus.rdata, 16'h0); else pass_cnt++;
    total_cnt++; if (bus.write_out !== 16'h0) $display("FAIL reset_write_out got %h want %h", bus.write_out, 16'h0); else pass_cnt++;
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.stall !== 1'b0) $display("FAIL reset_stall got %b want 0", bus.stall); else pass_cnt++;
    drive_idle();
    rst = 1'b1;
    bus.rd_en = 1; bus.addr = 4'd9;
    step();
    drive_idle();
    total_cnt++; if (bus.rdata !== 16'h0008) $display("FAIL reset_status got %h want %h", bus.rdata, 16'h0008); else pass_cnt++;
  endtask

  task automatic test_capture();
    drive_idle();
    in_strobe = 2'b01; read_in[15:0] = 16'h13b0; read_in[31:16] = 16'($urandom);
    step();
    in_strobe = '0; bus.rd_en = 1; bus.addr = 4'd0;
    step();
    total_cnt++; if (bus.rdata !== 16'h13b0) $display("FAIL capture_load got %h want %h", bus.rdata, 16'h13b0); else pass_cnt++;
    bus.addr = 4'd9;
    step();
    drive_idle();
    total_cnt++; if (bus.rdata !== 16'h0008) $display("FAIL capture_status got %h want %h", bus.rdata, 16'h0008); else pass_cnt++;
  endtask

  task automatic test_overrun();
    drive_idle();
    in_strobe = 2'b10; read_in[31:16] = 16'h1234;
    step();
    read_in[31:16] = 16'h0003;
    step();
    in_strobe = '0; bus.rd_en = 1; bus.addr = 4'd9;
    step();
    total_cnt++; if (bus.rdata !== 16'h000e) $display("FAIL overrun_status got %h want %h", bus.rdata, 16'h000e); else pass_cnt++;
    bus.addr = 4'd1;
    step();
    total_cnt++; if (bus.rdata !== 16'h0003) $display("FAIL overrun_load got %h want %h", bus.rdata, 16'h0003); else pass_cnt++;
    bus.addr = 4'd9;
    step();
    drive_idle();
    total_cnt++; if (bus.rdata !== 16'h0008) $display("FAIL overrun_cleared got %h want %h", bus.rdata, 16'h0008); else pass_cnt++;
  endtask

  task automatic test_fifo_full();
    logic [WIDTH-1:0] vals [4];
    vals[0] = 16'h000b; vals[1] = 16'h0003; vals[2] = 16'h1234; vals[3] = 16'hffff;
    drive_idle();
    for (int k = 0; k < 4; k++) begin
      bus.wr_en = 1; bus.addr = 4'd8; bus.wdata = vals[k];
      #1;
      total_cnt++; if (bus.stall !== 1'b0) $display("FAIL fill_stall%0d got %b want 0", k, bus.stall); else pass_cnt++;
      step();
    end
    bus.wr_en = 0; bus.rd_en = 1; bus.addr = 4'd9;
    step();
    total_cnt++; if (bus.rdata !== 16'h0090) $display("FAIL full_status got %h want %h", bus.rdata, 16'h0090); else pass_cnt++;
    bus.rd_en = 0; bus.wr_en = 1; bus.addr = 4'd8; bus.wdata = 16'hbeef;
    #1;
    total_cnt++; if (bus.stall !== 1'b1) $display("FAIL full_stall got %b want 1", bus.stall); else pass_cnt++;
    step();
    total_cnt++; if (bus.write_out !== 16'h000b) $display("FAIL full_head got %h want %h", bus.write_out, 16'h000b); else pass_cnt++;
    bus.out_ready = 1;
    #1;
    total_cnt++; if (bus.stall !== 1'b1) $display("FAIL full_pop_stall got %b want 1", bus.stall); else pass_cnt++;
    step();
    bus.wr_en = 0;
    for (int k = 1; k < 4; k++) begin
      total_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL drain_valid%0d got %b want 1", k, bus.out_valid); else pass_cnt++;
      total_cnt++; if (bus.write_out !== vals[k]) $display("FAIL drain_data%0d got %h want %h", k, bus.write_out, vals[k]); else pass_cnt++;
      step();
    end
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL drain_empty got %b want 0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.write_out !== 16'h0) $display("FAIL drain_zero got %h want 0", bus.write_out); else pass_cnt++;
    drive_idle();
  endtask

  task automatic test_stream();
    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] v;
    logic [WIDTH-1:0] e;
    drive_idle();
    for (int k = 0; k < 2; k++) begin
      v = 16'($urandom);
      bus.wr_en = 1; bus.addr = 4'd8; bus.wdata = v; exp_q.push_back(v);
      step();
    end
    bus.out_ready = 1;
    for (int k = 0; k < 10; k++) begin
      v = 16'($urandom);
      bus.wdata = v; exp_q.push_back(v);
      #1;
      e = exp_q.pop_front();
      total_cnt++; if (bus.stall !== 1'b0) $display("FAIL stream_stall%0d got %b want 0", k, bus.stall); else pass_cnt++;
      total_cnt++; if (bus.write_out !== e) $display("FAIL stream_data%0d got %h want %h", k, bus.write_out, e); else pass_cnt++;
      step();
    end
    bus.wr_en = 0; bus.out_ready = 0; bus.rd_en = 1; bus.addr = 4'd9;
    step();
    total_cnt++; if (bus.rdata !== 16'h0040) $display("FAIL stream_count got %h want %h", bus.rdata, 16'h0040); else pass_cnt++;
    bus.rd_en = 0; bus.out_ready = 1;
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      total_cnt++; if (bus.write_out !== e) $display("FAIL stream_tail%0d got %h want %h", k, bus.write_out, e); else pass_cnt++;
      step();
    end
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL stream_empty got %b want 0", bus.out_valid); else pass_cnt++;
    drive_idle();
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] exp_wo;
    bit exp_stall;
    int errs = 0;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 5))
        0: bus.addr = 4'd0;
        1: bus.addr = 4'd1;
        2, 3: bus.addr = 4'd8;
        4: bus.addr = 4'd9;
        default: bus.addr = 4'($urandom);
      endcase
      bus.rd_en = 1'($urandom);
      bus.wr_en = 1'($urandom);
      bus.wdata = 16'($urandom);
      bus.out_ready = ($urandom_range(0, 3) == 0);
      in_strobe = 2'($urandom);
      read_in = $urandom;
      #1;
      exp_stall = bus.wr_en && bus.addr == 4'd8 && m_q.size() == DEPTH;
      total_cnt++; if (bus.stall !== exp_stall) begin $display("FAIL rand_stall@%0d got %b want %b", n, bus.stall, exp_stall); errs++; end else pass_cnt++;
      step();
      exp_wo = (m_q.size() != 0) ? m_q[0] : '0;
      total_cnt++; if (bus.rdata !== m_rdata) begin $display("FAIL rand_rdata@%0d got %h want %h", n, bus.rdata, m_rdata); errs++; end else pass_cnt++;
      total_cnt++; if (bus.write_out !== exp_wo) begin $display("FAIL rand_write_out@%0d got %h want %h", n, bus.write_out, exp_wo); errs++; end else pass_cnt++;
      total_cnt++; if (bus.out_valid !== (m_q.size() != 0)) begin $display("FAIL rand_out_valid@%0d got %b want %b", n, bus.out_valid, m_q.size() != 0); errs++; end else pass_cnt++;
      if (errs > 10) break;
    end
    drive_idle();
  endtask

  task automatic test_reset_mid();
    drive_idle();
    bus.out_ready = 1;
    for (int k = 0; k < 8 && m_q.size() != 0; k++) step();
    bus.out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      bus.wr_en = 1; bus.addr = 4'd8; bus.wdata = 16'($urandom | 1);
      in_strobe = (k == 0) ? 2'b01 : 2'b00; read_in = $urandom;
      step();
    end
    drive_idle();
    bus.rd_en = 1; bus.addr = 4'd9;
    step();
    bus.rd_en = 0;
    total_cnt++; if (bus.rdata !== m_rdata) $display("FAIL pre_reset_status got %h want %h", bus.rdata, m_rdata); else pass_cnt++;
    total_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL pre_reset_valid got %b want 1", bus.out_valid); else pass_cnt++;
    #2 rst = 1'b0;
    reset_model();
    #1;
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL mid_reset_valid got %b want 0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.write_out !== 16'h0) $display("FAIL mid_reset_write_out got %h want 0", bus.write_out); else pass_cnt++;
    total_cnt++; if (bus.rdata !== 16'h0) $display("FAIL mid_reset_rdata got %h want 0", bus.rdata); else pass_cnt++;
    @(posedge clock);
    #1 rst = 1'b1;
    bus.rd_en = 1; bus.addr = 4'd9;
    step();
    drive_idle();
    total_cnt++; if (bus.rdata !== 16'h0008) $display("FAIL post_reset_status got %h want %h", bus.rdata, 16'h0008); else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d checks", total_cnt);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_capture();
    test_overrun();
    test_fifo_full();
    test_stream();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
